bike_mult_ctrl: RTL and testbench
=================================

# bike_mult_ctrl

Control sequencer for the sparse-by-dense cyclic polynomial multiplier. It walks all WEIGHT positions of the sparse operand and, for each position, streams all R_BLOCKS words of the dense operand. It generates the read addresses for both operand memories. It also produces delayed write strobes, aligned to the memory read latency, for the XOR accumulator that follows it in the datapath.

## Interface
- WEIGHT, 71, number of sparse positions (≥1)
- R_BLOCKS, 385, dense words per polynomial (≥2)
- LOGW, 7, sparse address width (2^LOGW ≥ WEIGHT)
- LOGB, 9, dense/accumulator address width (2^LOGB ≥ R_BLOCKS)
- PIPE_LAT, 2, read latency of both memories in cycles (≥1)

- clk  in  1  system clock, all logic on rising edge
- resetn  in  1  asynchronous, active-low reset
- start  in  1  begin a multiplication; sampled only in IDLE
- abort  in  1  synchronous cancel, any state
- sparse_rden  out  1  sparse memory read enable
- sparse_addr  out  LOGW  sparse position index i
- pos_valid  out  1  sparse read data valid this cycle; datapath loads shift amount
- dense_rden  out  1  dense memory read enable
- dense_addr  out  LOGB  dense word index j
- acc_we  out  1  accumulator write enable (dense_rden delayed PIPE_LAT)
- acc_addr  out  LOGB  accumulator address (dense_addr delayed PIPE_LAT)
- acc_first  out  1  with acc_we: overwrite instead of XOR (position 0)
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse

## Operation
- Reset: state IDLE; i=0, j=0, wait counter 0, delay lines cleared; every output 0.
- States:
  - IDLE: start=1 → LOAD_POS.
  - LOAD_POS (1 cycle): sparse_rden=1, sparse_addr=i → WAIT_POS.
  - WAIT_POS (PIPE_LAT cycles): pos_valid=1 in the last cycle only → STREAM with j=0.
  - STREAM (R_BLOCKS cycles): dense_rden=1, dense_addr=j, j++. After j=R_BLOCKS-1:
    - if i<WEIGHT-1: i++ → LOAD_POS.
    - else → DRAIN.
  - DRAIN (PIPE_LAT cycles): no new reads; delayed strobes flush → DONE.
  - DONE (1 cycle): done=1 → IDLE; i and j cleared.
- busy=1 in LOAD_POS, WAIT_POS, STREAM and DRAIN. busy=0 in IDLE and DONE.
- Delay line: a PIPE_LAT-deep shift register carries {dense_rden, dense_addr, i==0} and drives {acc_we, acc_addr, acc_first}.
- sparse_addr and dense_addr hold their last value when the matching rden is 0.
- Counters wrap to 0 at terminal count, never at the power of two. Addresses never exceed WEIGHT-1 / R_BLOCKS-1.
- start while busy or in DONE: ignored, no queuing.
- abort=1 in any state:
  - next cycle IDLE; counters and delay line cleared.
  - acc_we forced 0 from the next cycle on.
  - done is not pulsed.
- abort and start high in the same cycle: abort wins.
- resetn low mid-operation: immediate return to reset state; in-flight strobes discarded.

## Timing
- start sampled high at edge k:
  - busy=1 from cycle k+1.
  - sparse_rden=1 in cycle k+1.
  - pos_valid=1 in cycle k+1+PIPE_LAT.
  - first dense_rden in cycle k+2+PIPE_LAT.
- Per-position period P = 1+PIPE_LAT+R_BLOCKS cycles.
- acc_we follows each dense_rden exactly PIPE_LAT cycles later with the same address.
- done=1 in cycle k+1+WEIGHT·P+PIPE_LAT, the cycle after the last acc_we. busy=0 in that cycle.
- Earliest next accepted start: the cycle after done, i.e. back-to-back operations with one idle cycle.
- All outputs are registered; no combinational path from start/abort to any output.

## Test plan
- Reset: hold resetn=0 with start toggling → all outputs 0. Release, no start → outputs stay 0.
- Nominal (WEIGHT=2, R_BLOCKS=4, PIPE_LAT=2), start at edge 0:
  - sparse_rden in cycles 1 and 8; pos_valid in cycles 3 and 10.
  - dense_addr 0..3 in cycles 4–7 and 11–14.
  - acc_we in cycles 6–9 (acc_first=1) and 13–16 (acc_first=0).
  - done in cycle 17.
- Default parameters: count acc_we pulses = 71·385 = 27335. Each address 0..384 appears 71 times; acc_first set on exactly the first 385. done 1+71·388+2 cycles after start.
- Start while busy: pulse start at mid-STREAM and in the DONE cycle → no effect; total cycle count unchanged.
- Abort during STREAM, position 1, j=2: IDLE next cycle; acc_we 0 from the next cycle on; no done. A fresh start then completes normally with the nominal count.
- Async reset asserted mid-DRAIN → outputs 0 immediately, no done. Simultaneous abort+start in IDLE → stays IDLE, busy stays 0.

Source files
------------

// File: rtl/bike_mult_ctrl.sv
// Control sequencer for the sparse-by-dense cyclic multiplier: walks sparse positions, streams
// dense words, and emits latency-aligned accumulator strobes.
module bike_mult_ctrl #(
  parameter int unsigned WEIGHT   = 71,
  parameter int unsigned R_BLOCKS = 385,
  parameter int unsigned LOGW     = 7,
  parameter int unsigned LOGB     = 9,
  parameter int unsigned PIPE_LAT = 2
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  input  logic            abort,
  output logic            sparse_rden,
  output logic [LOGW-1:0] sparse_addr,
  output logic            pos_valid,
  output logic            dense_rden,
  output logic [LOGB-1:0] dense_addr,
  output logic            acc_we,
  output logic [LOGB-1:0] acc_addr,
  output logic            acc_first,
  output logic            busy,
  output logic            done
);

  localparam int unsigned WW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  localparam logic [LOGW-1:0] ILast = LOGW'(WEIGHT - 1);
  localparam logic [LOGW-1:0] IOne  = LOGW'(1);
  localparam logic [LOGB-1:0] JLast = LOGB'(R_BLOCKS - 1);
  localparam logic [LOGB-1:0] JOne  = LOGB'(1);
  localparam logic [WW-1:0]   WLast = WW'(PIPE_LAT - 1);
  localparam logic [WW-1:0]   WOne  = WW'(1);

  typedef enum logic [2:0] {
    StIdle,
    StLoadPos,
    StWaitPos,
    StStream,
    StDrain,
    StDone
  } state_e;

  state_e          state_q;
  logic [LOGW-1:0] i_q;
  logic [LOGB-1:0] j_q;
  logic [WW-1:0]   wcnt_q;

  // Delay line mirrors the memory read latency so the accumulator sees data with its strobe.
  logic            dl_we    [PIPE_LAT];
  logic [LOGB-1:0] dl_addr  [PIPE_LAT];
  logic            dl_first [PIPE_LAT];

  assign acc_we    = dl_we[PIPE_LAT-1];
  assign acc_addr  = dl_addr[PIPE_LAT-1];
  assign acc_first = dl_first[PIPE_LAT-1];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      i_q         <= '0;
      j_q         <= '0;
      wcnt_q      <= '0;
      sparse_rden <= 1'b0;
      sparse_addr <= '0;
      pos_valid   <= 1'b0;
      dense_rden  <= 1'b0;
      dense_addr  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      for (int k = 0; k < PIPE_LAT; k++) begin
        dl_we[k]    <= 1'b0;
        dl_addr[k]  <= '0;
        dl_first[k] <= 1'b0;
      end
    end else if (abort) begin
      // Addresses hold; everything that could cause a write or a completion is dropped.
      state_q     <= StIdle;
      i_q         <= '0;
      j_q         <= '0;
      wcnt_q      <= '0;
      sparse_rden <= 1'b0;
      pos_valid   <= 1'b0;
      dense_rden  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      for (int k = 0; k < PIPE_LAT; k++) begin
        dl_we[k]    <= 1'b0;
        dl_addr[k]  <= '0;
        dl_first[k] <= 1'b0;
      end
    end else begin
      dl_we[0]    <= dense_rden;
      dl_addr[0]  <= dense_addr;
      dl_first[0] <= dense_rden && (i_q == '0);
      for (int k = 1; k < PIPE_LAT; k++) begin
        dl_we[k]    <= dl_we[k-1];
        dl_addr[k]  <= dl_addr[k-1];
        dl_first[k] <= dl_first[k-1];
      end

      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q     <= StLoadPos;
            sparse_rden <= 1'b1;
            sparse_addr <= i_q;
            busy        <= 1'b1;
          end
        end
        StLoadPos: begin
          state_q     <= StWaitPos;
          sparse_rden <= 1'b0;
          wcnt_q      <= '0;
          pos_valid   <= (PIPE_LAT == 1);
        end
        StWaitPos: begin
          if (wcnt_q == WLast) begin
            state_q    <= StStream;
            pos_valid  <= 1'b0;
            dense_rden <= 1'b1;
            dense_addr <= '0;
            j_q        <= '0;
          end else begin
            wcnt_q    <= wcnt_q + WOne;
            pos_valid <= ((wcnt_q + WOne) == WLast);
          end
        end
        StStream: begin
          if (j_q == JLast) begin
            dense_rden <= 1'b0;
            j_q        <= '0;
            if (i_q < ILast) begin
              i_q         <= i_q + IOne;
              state_q     <= StLoadPos;
              sparse_rden <= 1'b1;
              sparse_addr <= i_q + IOne;
            end else begin
              state_q <= StDrain;
              wcnt_q  <= '0;
            end
          end else begin
            j_q        <= j_q + JOne;
            dense_addr <= j_q + JOne;
          end
        end
        StDrain: begin
          if (wcnt_q == WLast) begin
            state_q <= StDone;
            done    <= 1'b1;
            busy    <= 1'b0;
            i_q     <= '0;
            j_q     <= '0;
            wcnt_q  <= '0;
          end else begin
            wcnt_q <= wcnt_q + WOne;
          end
        end
        StDone: begin
          state_q <= StIdle;
          done    <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bike_mult_ctrl.sv
// Directed bench: small instance (W=2, R=4, L=2) for cycle-exact traces, default instance for
// full-size pulse accounting.
module tb_bike_mult_ctrl;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic start_b = 1'b0;
  logic abort_b = 1'b0;

  logic       s_srd, s_pv, s_drd, s_awe, s_afirst, s_busy, s_done;
  logic [1:0] s_saddr;
  logic [2:0] s_daddr, s_aaddr;

  logic       b_srd, b_pv, b_drd, b_awe, b_afirst, b_busy, b_done;
  logic [6:0] b_saddr;
  logic [8:0] b_daddr, b_aaddr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bike_mult_ctrl #(
    .WEIGHT(2), .R_BLOCKS(4), .LOGW(2), .LOGB(3), .PIPE_LAT(2)
  ) u_small (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort),
    .sparse_rden(s_srd), .sparse_addr(s_saddr), .pos_valid(s_pv),
    .dense_rden(s_drd), .dense_addr(s_daddr),
    .acc_we(s_awe), .acc_addr(s_aaddr), .acc_first(s_afirst),
    .busy(s_busy), .done(s_done)
  );

  bike_mult_ctrl u_big (
    .clk(clk), .resetn(resetn), .start(start_b), .abort(abort_b),
    .sparse_rden(b_srd), .sparse_addr(b_saddr), .pos_valid(b_pv),
    .dense_rden(b_drd), .dense_addr(b_daddr),
    .acc_we(b_awe), .acc_addr(b_aaddr), .acc_first(b_afirst),
    .busy(b_busy), .done(b_done)
  );

  task automatic chk(input string tag, input int cyc, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag, input int cyc);
    chk({tag, "_srd"}, cyc, 32'(s_srd), 0);
    chk({tag, "_saddr"}, cyc, 32'(s_saddr), 0);
    chk({tag, "_pv"}, cyc, 32'(s_pv), 0);
    chk({tag, "_drd"}, cyc, 32'(s_drd), 0);
    chk({tag, "_daddr"}, cyc, 32'(s_daddr), 0);
    chk({tag, "_awe"}, cyc, 32'(s_awe), 0);
    chk({tag, "_aaddr"}, cyc, 32'(s_aaddr), 0);
    chk({tag, "_afirst"}, cyc, 32'(s_afirst), 0);
    chk({tag, "_busy"}, cyc, 32'(s_busy), 0);
    chk({tag, "_done"}, cyc, 32'(s_done), 0);
  endtask

  // Start at edge 0, then check cycles 1..19 against the hand-derived nominal trace.
  // pa/pb: cycles with a stray start; ab: abort cycle; rs: reset cycle (0 = none).
  task automatic run_small(input int pa, input int pb, input int ab, input int rs);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 19; c++) begin
      logic kill, e_srd, e_pv, e_drd, e_awe, e_af, e_done, e_busy;
      int   e_sa, e_da, e_aa;
      kill   = (ab != 0 && c > ab) || (rs != 0 && c > rs);
      e_srd  = !kill && (c == 1 || c == 8);
      e_pv   = !kill && (c == 3 || c == 10);
      e_drd  = !kill && ((c >= 4 && c <= 7) || (c >= 11 && c <= 14));
      e_awe  = !kill && ((c >= 6 && c <= 9) || (c >= 13 && c <= 16));
      e_af   = !kill && (c >= 6 && c <= 9);
      e_done = !kill && (c == 17);
      e_busy = !kill && (c >= 1 && c <= 16);
      e_sa   = (c == 1) ? 0 : 1;
      e_da   = (c <= 7) ? c - 4 : c - 11;
      e_aa   = (c <= 9) ? c - 6 : c - 13;
      chk("busy", c, 32'(s_busy), 32'(e_busy));
      chk("sparse_rden", c, 32'(s_srd), 32'(e_srd));
      chk("pos_valid", c, 32'(s_pv), 32'(e_pv));
      chk("dense_rden", c, 32'(s_drd), 32'(e_drd));
      chk("acc_we", c, 32'(s_awe), 32'(e_awe));
      chk("acc_first", c, 32'(s_afirst), 32'(e_af));
      chk("done", c, 32'(s_done), 32'(e_done));
      if (e_srd) chk("sparse_addr", c, 32'(s_saddr), 32'(e_sa));
      if (e_drd) chk("dense_addr", c, 32'(s_daddr), 32'(e_da));
      if (e_awe) chk("acc_addr", c, 32'(s_aaddr), 32'(e_aa));
      if (c == rs + 1 && rs != 0) resetn = 1'b1;
      start = (c == pa) || (c == pb);
      abort = (c == ab);
      if (c == rs) begin
        resetn = 1'b0;
        #1;
        chk_zero("rst_now", c);
      end
      @(negedge clk);
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  int cnt [512];
  int nwe, nfirst, bad_first, addr_bad, done_c, exp_cnt;

  initial begin
    // Reset held with start toggling, then released with no start.
    for (int c = 0; c < 4; c++) begin
      start = c[0];
      @(negedge clk);
      chk_zero("in_reset", c);
    end
    start  = 1'b0;
    resetn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk_zero("post_reset", c);
    end

    run_small(0, 0, 0, 0);
    run_small(5, 17, 0, 0);
    run_small(0, 0, 13, 0);
    run_small(0, 0, 0, 0);
    run_small(0, 0, 0, 15);

    // Simultaneous abort and start in IDLE: abort wins.
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      chk("abort_start_busy", c, 32'(s_busy), 0);
      chk("abort_start_srd", c, 32'(s_srd), 0);
      @(negedge clk);
    end

    // Full-size run on the default-parameter instance.
    foreach (cnt[a]) cnt[a] = 0;
    nwe = 0; nfirst = 0; bad_first = 0; addr_bad = 0; done_c = -1;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int c = 1; c <= 30000; c++) begin
      if (b_awe) begin
        nwe++;
        cnt[b_aaddr]++;
        if (b_afirst) begin
          nfirst++;
          if (nwe > 385) bad_first++;
        end
      end
      if (b_done) begin
        done_c = c;
        chk("big_busy_at_done", c, 32'(b_busy), 0);
        break;
      end
      @(negedge clk);
    end
    for (int a = 0; a < 512; a++) begin
      exp_cnt = (a < 385) ? 71 : 0;
      if (cnt[a] != exp_cnt) addr_bad++;
    end
    chk("big_done_cycle", 0, 32'(done_c), 32'd27551);
    chk("big_acc_we_count", 0, 32'(nwe), 32'd27335);
    chk("big_first_count", 0, 32'(nfirst), 32'd385);
    chk("big_first_late", 0, 32'(bad_first), 0);
    chk("big_addr_hist", 0, 32'(addr_bad), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
